// File: rtl/pe_row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_skew_feeder
// Brief    : Vector FIFO feeding the PE array left edge with a diagonal row skew.
// Revision : 1.0 - initial release
// ============================================================================
module pe_row_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         FD_clk,
  input  logic                         FD_rst,
  input  logic                         FD_flush,
  input  logic                         FD_stall,
  input  logic                         FD_in_valid,
  output logic                         FD_in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   FD_in_data,
  output logic [ROWS-1:0]              FD_left_en,
  output logic [ROWS*DATA_WIDTH-1:0]   FD_data_left,
  output logic                         FD_busy,
  output logic [$clog2(DEPTH+1)-1:0]   FD_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [ROWS*DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]               r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]               r_count, w_count_nxt;
  logic                        w_can_accept, w_push, w_pop;
  logic [ROWS*DATA_WIDTH-1:0]  w_head;
  logic [ROWS-1:0]             w_pend;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign w_can_accept = !FD_flush && (r_count < C_DEPTH);
  assign FD_in_ready  = !FD_rst && w_can_accept;
  assign w_push       = FD_in_valid && w_can_accept;
  assign w_pop        = (r_count != '0) && !FD_stall && !FD_flush;
  assign w_head       = r_mem[r_rd_ptr];
  assign FD_count     = r_count;
  assign FD_busy      = (r_state != ST_IDLE);

  always_comb begin
    w_count_nxt = r_count;
    if (FD_flush)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge FD_clk or posedge FD_rst) begin
    if (FD_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (FD_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
    end
  end

  always_ff @(posedge FD_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= FD_in_data;
  end

  // Lane r is r+1 stages deep; data only advances behind a valid bit so the
  // output register keeps the last emitted element while the lane is empty.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0]            r_v;
    logic [r:0]            w_v_nxt;
    logic [DATA_WIDTH-1:0] r_d [r+1];

    always_comb begin
      w_v_nxt = r_v;
      if (FD_flush) begin
        w_v_nxt = '0;
      end else if (!FD_stall) begin
        for (int s = r; s > 0; s--) w_v_nxt[s] = r_v[s-1];
        w_v_nxt[0] = w_pop;
      end
    end

    always_ff @(posedge FD_clk or posedge FD_rst) begin
      if (FD_rst) begin
        r_v <= '0;
        for (int s = 0; s <= r; s++) r_d[s] <= '0;
      end else begin
        r_v <= w_v_nxt;
        if (FD_flush) begin
          for (int s = 0; s <= r; s++) r_d[s] <= '0;
        end else if (!FD_stall) begin
          if (w_pop) r_d[0] <= w_head[r*DATA_WIDTH +: DATA_WIDTH];
          for (int s = 1; s <= r; s++) begin
            if (r_v[s-1]) r_d[s] <= r_d[s-1];
          end
        end
      end
    end

    assign FD_left_en[r]                              = r_v[r] && !FD_stall;
    assign FD_data_left[r*DATA_WIDTH +: DATA_WIDTH]   = r_d[r];

    // Drain is complete once the last element sits in its output register.
    if (r == 0) begin : g_pend_none
      assign w_pend[r] = 1'b0;
    end else begin : g_pend_chain
      assign w_pend[r] = |w_v_nxt[r-1:0];
    end
  end

  always_ff @(posedge FD_clk or posedge FD_rst) begin
    if (FD_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (FD_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_count_nxt == '0) w_state_nxt = (|w_pend) ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (w_push)        w_state_nxt = ST_RUN;
          else if (!(|w_pend)) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_row_skew_feeder
// Brief    : Directed bench for pe_row_skew_feeder with a per-row scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_row_skew_feeder;

  localparam int DW    = 32;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = ROWS * DW;

  logic            FD_clk = 1'b0;
  logic            FD_rst, FD_flush, FD_stall, FD_in_valid;
  logic            FD_in_ready, FD_busy;
  logic [VW-1:0]   FD_in_data, FD_data_left;
  logic [ROWS-1:0] FD_left_en;
  logic [CW-1:0]   FD_count;

  int              n_checks = 0;
  int              n_pass   = 0;
  int              n_acc    = 0;
  logic            acc;
  logic [DW-1:0]   sb_q [ROWS][$];
  logic [ROWS-1:0] exp_en;
  logic [VW-1:0]   vec;

  pe_row_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .DEPTH(DEPTH)) u_dut (
    .FD_clk       (FD_clk),
    .FD_rst       (FD_rst),
    .FD_flush     (FD_flush),
    .FD_stall     (FD_stall),
    .FD_in_valid  (FD_in_valid),
    .FD_in_ready  (FD_in_ready),
    .FD_in_data   (FD_in_data),
    .FD_left_en   (FD_left_en),
    .FD_data_left (FD_data_left),
    .FD_busy      (FD_busy),
    .FD_count     (FD_count)
  );

  always #5 FD_clk = ~FD_clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: note acceptance before the edge, then score emissions after it.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge FD_clk);
    acc = FD_in_valid && FD_in_ready;
    @(posedge FD_clk);
    #1;
    if (acc) begin
      n_acc++;
      for (int r = 0; r < ROWS; r++) sb_q[r].push_back(FD_in_data[r*DW +: DW]);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (FD_left_en[r]) begin
        n_checks++;
        assert (sb_q[r].size() != 0) n_pass++;
        else $error("FAIL row%0d_emit: observed emission expected none", r);
        if (sb_q[r].size() != 0) begin
          e = sb_q[r].pop_front();
          chk($sformatf("row%0d_data", r), VW'(FD_data_left[r*DW +: DW]), VW'(e));
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    FD_rst = 1'b1; FD_flush = 1'b0; FD_stall = 1'b0;
    FD_in_valid = 1'b1; FD_in_data = {ROWS{32'hDEAD_BEEF}};

    // Reset held with valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", VW'(FD_in_ready), VW'(0));
      chk("rst_en",    VW'(FD_left_en),  VW'(0));
      chk("rst_data",  FD_data_left,     VW'(0));
      chk("rst_busy",  VW'(FD_busy),     VW'(0));
      chk("rst_count", VW'(FD_count),    VW'(0));
    end
    FD_rst = 1'b0; FD_in_valid = 1'b0;
    #1;
    chk("rel_ready", VW'(FD_in_ready), VW'(1));
    chk("rel_busy",  VW'(FD_busy),     VW'(0));
    chk("rel_acc",   VW'(n_acc),       VW'(0));

    // Single vector
    vec = {32'h33, 32'h22, 32'h11, 32'h00};
    FD_in_valid = 1'b1; FD_in_data = vec;
    tick();
    chk("single_acc",   VW'(acc),        VW'(1));
    chk("single_count", VW'(FD_count),   VW'(1));
    chk("single_busy0", VW'(FD_busy),    VW'(1));
    chk("single_en0",   VW'(FD_left_en), VW'(0));
    FD_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_en",   VW'(FD_left_en), VW'(4'b0001 << i));
      chk("single_busy", VW'(FD_busy),    VW'(i < 3));
    end
    tick();
    chk("single_en_done", VW'(FD_left_en), VW'(0));
    chk("single_hold",    FD_data_left,    vec);

    // Back-to-back stream of 8 vectors
    for (int t = 0; t < 13; t++) begin
      if (t < 8) begin
        FD_in_valid = 1'b1;
        for (int r = 0; r < ROWS; r++) FD_in_data[r*DW +: DW] = DW'(r * 16 + t + 1);
      end else begin
        FD_in_valid = 1'b0;
      end
      tick();
      for (int r = 0; r < ROWS; r++) exp_en[r] = (t >= 1 + r) && (t <= 8 + r);
      chk("stream_en",     VW'(FD_left_en),    VW'(exp_en));
      chk("stream_count",  VW'(FD_count <= 1), VW'(1));
    end

    // Fill under stall, then backpressure on the 5th vector
    FD_stall = 1'b1; FD_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < ROWS; r++) FD_in_data[r*DW +: DW] = DW'(32'hA0 + i + r * 256);
      tick();
      chk("fill_acc", VW'(acc),        VW'(1));
      chk("fill_en",  VW'(FD_left_en), VW'(0));
    end
    chk("fill_count", VW'(FD_count),    VW'(4));
    chk("fill_ready", VW'(FD_in_ready), VW'(0));
    chk("fill_busy",  VW'(FD_busy),     VW'(1));
    for (int r = 0; r < ROWS; r++) FD_in_data[r*DW +: DW] = DW'(32'hA4 + r * 256);
    tick();
    chk("fill_held_off", VW'(acc),      VW'(0));
    chk("fill_count_4",  VW'(FD_count), VW'(4));
    FD_stall = 1'b0;
    tick();
    chk("fill_full_pop_acc", VW'(acc),         VW'(0));
    chk("fill_pop_count",    VW'(FD_count),    VW'(3));
    chk("fill_pop_en",       VW'(FD_left_en),  VW'(1));
    chk("fill_pop_ready",    VW'(FD_in_ready), VW'(1));
    tick();
    chk("fill_fifth_acc",   VW'(acc),      VW'(1));
    chk("fill_fifth_count", VW'(FD_count), VW'(3));
    FD_in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("fill_drain_busy",  VW'(FD_busy),  VW'(0));
    chk("fill_drain_count", VW'(FD_count), VW'(0));

    // Stall two cycles while rows 2 and 3 are still in flight
    FD_in_valid = 1'b1; FD_in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    tick();
    chk("stall_acc", VW'(acc), VW'(1));
    FD_in_valid = 1'b0;
    tick();
    chk("stall_en_r0", VW'(FD_left_en), VW'(4'b0001));
    tick();
    chk("stall_en_r1", VW'(FD_left_en), VW'(4'b0010));
    FD_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_en_off", VW'(FD_left_en), VW'(0));
      chk("stall_busy",   VW'(FD_busy),    VW'(1));
    end
    FD_stall = 1'b0;
    tick();
    chk("stall_en_r2", VW'(FD_left_en), VW'(4'b0100));
    tick();
    chk("stall_en_r3",  VW'(FD_left_en), VW'(4'b1000));
    chk("stall_busy_0", VW'(FD_busy),    VW'(0));
    tick();
    chk("stall_en_done", VW'(FD_left_en), VW'(0));

    // Flush with three queued vectors and a partly emitted one in the lanes
    FD_in_valid = 1'b1; FD_in_data = {4{32'hC0}};
    tick();
    FD_in_data = {4{32'hC1}};
    tick();
    chk("flush_pre_en", VW'(FD_left_en), VW'(1));
    FD_stall = 1'b1; FD_in_data = {4{32'hC2}};
    tick();
    FD_in_data = {4{32'hC3}};
    tick();
    chk("flush_pre_count", VW'(FD_count), VW'(3));
    FD_flush = 1'b1; FD_in_data = {4{32'hC4}};
    #1;
    chk("flush_ready", VW'(FD_in_ready), VW'(0));
    tick();
    chk("flush_acc",   VW'(acc),        VW'(0));
    chk("flush_count", VW'(FD_count),   VW'(0));
    chk("flush_en",    VW'(FD_left_en), VW'(0));
    chk("flush_busy",  VW'(FD_busy),    VW'(0));
    chk("flush_data",  FD_data_left,    VW'(0));
    for (int r = 0; r < ROWS; r++) sb_q[r].delete();
    FD_flush = 1'b0; FD_stall = 1'b0; FD_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_flush_en",    VW'(FD_left_en), VW'(0));
      chk("post_flush_count", VW'(FD_count),   VW'(0));
    end

    for (int r = 0; r < ROWS; r++) chk($sformatf("sb_row%0d_left", r), VW'(sb_q[r].size()), VW'(0));
    chk("accept_total", VW'(n_acc), VW'(19));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
